// File: rtl/tick_stopwatch.sv
// tick_stopwatch
//   Turns the upstream timer's single-cycle tick strobe into a BCD mm:ss
//   stopwatch (00:00..59:59). A small FSM handles the start/stop/clear/lap
//   commands. The lap function freezes the display while live counting
//   carries on underneath.
//
//   State table:
//     state  | meaning
//     IDLE   | zeroed, waiting for start
//     RUN    | counting ticks
//     PAUSE  | counting suspended, prescaler phase kept
//     HALTED | saturated at 59:59 (WRAP=0), only clear leaves
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   tick               single-cycle strobe from upstream timer
//   start/stop/clear/lap  command pulses (priority clear > stop > start > lap)
//   sec_ones..min_tens displayed BCD digits (live count, or latch while lap_hold)
//   running            high in RUN
//   lap_hold           display frozen on the latched value
//   sec_pulse          1-cycle strobe each time the live seconds advance
//   overflow           sticky flag set on 59:59 -> 00:00 roll (WRAP=1)
module tick_stopwatch #(
  parameter int TICKS_PER_SEC = 100,
  parameter bit WRAP          = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_hold,
  output logic       sec_pulse,
  output logic       overflow
);

  // A one-tick-per-second prescaler still needs a 1-bit register to exist.
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_TC = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  // Packed as {min_tens, min_ones, sec_tens, sec_ones}.
  logic [15:0]   live;
  logic [15:0]   latch;

  logic          count_en;
  logic          sec_adv;
  logic          at_max;
  logic [15:0]   live_inc;
  logic [15:0]   live_next;

  // Ticks coincident with clear or stop are dropped. Start in RUN is a no-op
  // and does not block the tick.
  assign count_en = (state == RUN) && tick && !clear && !stop;
  assign sec_adv  = count_en && (presc == PS_TC);
  assign at_max   = (live == 16'h5959);

  // BCD carry chain. At 59:59 every digit rolls, so the result is 00:00.
  always_comb begin
    live_inc = live;
    if (live[3:0] != 4'd9) begin
      live_inc[3:0] = live[3:0] + 4'd1;
    end else begin
      live_inc[3:0] = 4'd0;
      if (live[7:4] != 4'd5) begin
        live_inc[7:4] = live[7:4] + 4'd1;
      end else begin
        live_inc[7:4] = 4'd0;
        if (live[11:8] != 4'd9) begin
          live_inc[11:8] = live[11:8] + 4'd1;
        end else begin
          live_inc[11:8] = 4'd0;
          if (live[15:12] != 4'd5) begin
            live_inc[15:12] = live[15:12] + 4'd1;
          end else begin
            live_inc[15:12] = 4'd0;
          end
        end
      end
    end
  end

  always_comb begin
    live_next = live;
    if (sec_adv && !(at_max && !WRAP)) begin
      live_next = live_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      live      <= '0;
      latch     <= '0;
      running   <= 1'b0;
      lap_hold  <= 1'b0;
      sec_pulse <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sec_pulse <= sec_adv;
      if (clear) begin
        state    <= IDLE;
        presc    <= '0;
        live     <= '0;
        latch    <= '0;
        running  <= 1'b0;
        lap_hold <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (count_en) begin
          presc <= (presc == PS_TC) ? '0 : presc + PW'(1);
          live  <= live_next;
        end
        if (sec_adv && at_max) begin
          if (WRAP) begin
            overflow <= 1'b1;
          end else begin
            state   <= HALTED;
            running <= 1'b0;
          end
        end
        // Only the highest-priority asserted command is considered.
        if (stop) begin
          if (state == RUN) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end else if (start) begin
          if (state == IDLE || state == PAUSE) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end else if (lap) begin
          if (state == RUN || state == PAUSE) begin
            lap_hold <= ~lap_hold;
            // Capture the value this edge produces, so a coincident tick counts.
            if (!lap_hold) begin
              latch <= live_next;
            end
          end
        end
      end
    end
  end

  logic [15:0] disp;
  assign disp = lap_hold ? latch : live;
  assign {min_tens, min_ones, sec_tens, sec_ones} = disp;

endmodule

// File: tb/tb_tick_stopwatch.sv
module tb_tick_stopwatch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;

  logic [3:0] w_so, w_st, w_mo, w_mt;
  logic       w_run, w_lh, w_sp, w_ovf;
  logic [3:0] s_so, s_st, s_mo, s_mt;
  logic       s_run, s_lh, s_sp, s_ovf;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  tick_stopwatch #(.TICKS_PER_SEC(4), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .lap(lap),
    .sec_ones(w_so), .sec_tens(w_st), .min_ones(w_mo), .min_tens(w_mt),
    .running(w_run), .lap_hold(w_lh), .sec_pulse(w_sp), .overflow(w_ovf)
  );

  tick_stopwatch #(.TICKS_PER_SEC(4), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .lap(lap),
    .sec_ones(s_so), .sec_tens(s_st), .min_ones(s_mo), .min_tens(s_mt),
    .running(s_run), .lap_hold(s_lh), .sec_pulse(s_sp), .overflow(s_ovf)
  );

  logic [15:0] w_disp, s_disp;
  assign w_disp = {w_mt, w_mo, w_st, w_so};
  assign s_disp = {s_mt, s_mo, s_st, s_so};

  typedef struct {
    bit        tk, st, sp, cl, lp;
    bit [15:0] disp;
    bit        run, lh, pulse, ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    else
      passed++;
  endtask

  // One clock cycle with the given inputs; outputs are stable on return.
  task automatic cyc(input bit tk, input bit st, input bit sp, input bit cl, input bit lp);
    tick = tk; start = st; stop = sp; clear = cl; lap = lp;
    @(posedge clk);
    #1;
    tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic add(input bit tk, input bit st, input bit sp, input bit cl, input bit lp,
                     input bit [15:0] d, input bit r, input bit lh, input bit p, input bit o);
    vec_t v;
    v = '{tk, st, sp, cl, lp, d, r, lh, p, o};
    vecs.push_back(v);
  endtask

  int pulses_w, pulses_s;

  initial begin
    //  tk    st    sp    cl    lp    disp      run   lh    pulse ovf
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); // idle
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); // tick in IDLE
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0); // start+tick: not counted
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0); // 4th tick
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0); // presc=2
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0); // stop+tick
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0); // paused
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0); // resume
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0); // phase kept
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0); // start in RUN, tick counts
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0); // lap on
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b0); // live 0003, frozen
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0); // lap off
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0); // stop beats lap
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0); // lap in PAUSE
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b1, 1'b0); // live 0004
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); // clear+start+tick
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); // lap in IDLE

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst disp", w_disp, 16'h0000);
    chk("rst running", {15'd0, w_run}, 16'd0);
    chk("rst overflow", {15'd0, w_ovf}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      cyc(vecs[i].tk, vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].lp);
      chk($sformatf("v%0d disp", i), w_disp, vecs[i].disp);
      chk($sformatf("v%0d running", i), {15'd0, w_run}, {15'd0, vecs[i].run});
      chk($sformatf("v%0d lap_hold", i), {15'd0, w_lh}, {15'd0, vecs[i].lh});
      chk($sformatf("v%0d sec_pulse", i), {15'd0, w_sp}, {15'd0, vecs[i].pulse});
      chk($sformatf("v%0d overflow", i), {15'd0, w_ovf}, {15'd0, vecs[i].ovf});
    end

    // start then 8 ticks: 00:02, two second pulses
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulses_w = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (w_sp) pulses_w++;
    end
    chk("eight ticks disp", w_disp, 16'h0002);
    chk("eight ticks pulses", 16'(pulses_w), 16'd2);
    chk("eight ticks running", {15'd0, w_run}, 16'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Long run to 59:58 on both variants
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulses_w = 0;
    pulses_s = 0;
    for (int i = 0; i < 3598 * 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (w_sp) pulses_w++;
      if (s_sp) pulses_s++;
    end
    chk("preload wrap disp", w_disp, 16'h5958);
    chk("preload sat disp", s_disp, 16'h5958);
    chk("preload pulses", 16'(pulses_w), 16'd3598);
    chk("preload ovf", {15'd0, w_ovf}, 16'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("5959 wrap disp", w_disp, 16'h5959);
    chk("5959 sat disp", s_disp, 16'h5959);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap disp", w_disp, 16'h0000);
    chk("wrap overflow", {15'd0, w_ovf}, 16'd1);
    chk("wrap running", {15'd0, w_run}, 16'd1);
    chk("wrap sec_pulse", {15'd0, w_sp}, 16'd1);
    chk("sat disp", s_disp, 16'h5959);
    chk("sat running", {15'd0, s_run}, 16'd0);
    chk("sat sec_pulse", {15'd0, s_sp}, 16'd1);
    chk("sat overflow", {15'd0, s_ovf}, 16'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat held disp", s_disp, 16'h5959);
    chk("wrap sticky ovf", {15'd0, w_ovf}, 16'd1);
    chk("wrap after wrap disp", w_disp, 16'h0001);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat start ignored", {15'd0, s_run}, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat still held", s_disp, 16'h5959);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear sat disp", s_disp, 16'h0000);
    chk("clear sat running", {15'd0, s_run}, 16'd0);
    chk("clear wrap ovf", {15'd0, w_ovf}, 16'd0);
    chk("clear wrap disp", w_disp, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat restart running", {15'd0, s_run}, 16'd1);

    // Asynchronous reset in the middle of a cycle
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre-rst disp", w_disp, 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst disp", w_disp, 16'h0000);
    chk("async rst running", {15'd0, w_run}, 16'd0);
    chk("async rst sat disp", s_disp, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
